// File: rtl/mem_stage_access_unit.sv
// Memory-access stage: turns registered EX/MEM memory controls into a req/ack data-memory
// transaction, handling byte/half/word lanes, load extension, misalignment and ack timeout.
module mem_stage_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cMemRead,
    input  logic [1:0]  cMemWrite,
    input  logic [1:0]  cSEMux,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadReg2,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemByteEn,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic [31:0] oLoadData,
    output logic        oLoadValid,
    output logic        oStall,
    output logic        oAddrError,
    output logic        oBusError,
    output logic [1:0]  dbgState
);

    // Memory handshake: oMemReq rises with all request fields stable and stays high until the
    // single-cycle iMemAck (or the timeout); iMemAck outside an outstanding request is ignored.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state, nextState;
    size_t         accSize;
    logic [CW-1:0] timeoutCnt;
    logic          op, isStore, aligned, lastBusyCycle;
    logic [3:0]    reqByteEn;
    logic [31:0]   reqWData;
    logic [1:0]    formQ, offQ;
    logic [7:0]    laneByte;
    logic [15:0]   laneHalf;
    logic [31:0]   extLoad;

    // Decode of the incoming op; a store wins over a simultaneous read.
    always_comb begin
        op      = cMemRead | (cMemWrite != 2'b00);
        isStore = (cMemWrite != 2'b00);
        if (isStore) begin
            case (cMemWrite)
                2'b01:   accSize = SZ_WORD;
                2'b10:   accSize = SZ_HALF;
                default: accSize = SZ_BYTE;
            endcase
        end else begin
            case (cSEMux)
                2'b00:   accSize = SZ_WORD;
                2'b01:   accSize = SZ_HALF;
                default: accSize = SZ_BYTE;
            endcase
        end
        case (accSize)
            SZ_WORD: begin
                aligned   = (ALUResult[1:0] == 2'b00);
                reqByteEn = 4'b1111;
                reqWData  = ReadReg2;
            end
            SZ_HALF: begin
                aligned   = ~ALUResult[0];
                reqByteEn = ALUResult[1] ? 4'b1100 : 4'b0011;
                reqWData  = {2{ReadReg2[15:0]}};
            end
            default: begin
                aligned   = 1'b1;
                reqByteEn = 4'b0001 << ALUResult[1:0];
                reqWData  = {4{ReadReg2[7:0]}};
            end
        endcase
    end

    // Lane extraction uses the offset and form latched when the request was issued.
    always_comb begin
        laneByte = iMemRData[{offQ, 3'b000} +: 8];
        laneHalf = offQ[1] ? iMemRData[31:16] : iMemRData[15:0];
        case (formQ)
            2'b00:   extLoad = iMemRData;
            2'b01:   extLoad = {{16{laneHalf[15]}}, laneHalf};
            2'b10:   extLoad = {{24{laneByte[7]}}, laneByte};
            default: extLoad = {24'd0, laneByte};
        endcase
    end

    assign lastBusyCycle = (timeoutCnt == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (op) nextState = aligned ? BUSY : DONE;
            BUSY:    if (iMemAck || lastBusyCycle) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        oStall   = ~Reset & (((state == IDLE) & op) | (state == BUSY));
        dbgState = state;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            oMemReq    <= 1'b0;
            oMemWe     <= 1'b0;
            oMemAddr   <= 32'd0;
            oMemWData  <= 32'd0;
            oMemByteEn <= 4'd0;
            oLoadData  <= 32'd0;
            oLoadValid <= 1'b0;
            oAddrError <= 1'b0;
            oBusError  <= 1'b0;
            timeoutCnt <= '0;
            formQ      <= 2'd0;
            offQ       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    timeoutCnt <= '0;
                    if (op && aligned) begin
                        oMemReq    <= 1'b1;
                        oMemWe     <= isStore;
                        oMemAddr   <= {ALUResult[31:2], 2'b00};
                        oMemWData  <= isStore ? reqWData : 32'd0;
                        oMemByteEn <= isStore ? reqByteEn : 4'b1111;
                        formQ      <= cSEMux;
                        offQ       <= ALUResult[1:0];
                    end else if (op) begin
                        oAddrError <= 1'b1;
                    end
                end
                BUSY: begin
                    if (iMemAck) begin
                        oMemReq <= 1'b0;
                        if (!oMemWe) begin
                            oLoadData  <= extLoad;
                            oLoadValid <= 1'b1;
                        end
                    end else if (lastBusyCycle) begin
                        oMemReq   <= 1'b0;
                        oBusError <= 1'b1;
                        oLoadData <= 32'd0;
                    end else begin
                        timeoutCnt <= timeoutCnt + CW'(1);
                    end
                end
                default: begin
                    oLoadValid <= 1'b0;
                    oAddrError <= 1'b0;
                    oBusError  <= 1'b0;
                    timeoutCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed scenarios followed by randomized accesses,
// each checked against a behavioural model of the memory stage.
module tb_mem_stage_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cMemRead;
    logic [1:0]  cMemWrite;
    logic [1:0]  cSEMux;
    logic [31:0] ALUResult;
    logic [31:0] ReadReg2;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemByteEn;
    logic        iMemAck;
    logic [31:0] iMemRData;
    logic [31:0] oLoadData;
    logic        oLoadValid;
    logic        oStall;
    logic        oAddrError;
    logic        oBusError;
    logic [1:0]  dbgState;

    localparam int TIMEOUT = 16;

    int          nAssert = 0;
    int          nFail   = 0;
    logic [31:0] lastLoad;
    bit          loadKnown;

    mem_stage_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .cMemRead(cMemRead), .cMemWrite(cMemWrite), .cSEMux(cSEMux),
        .ALUResult(ALUResult), .ReadReg2(ReadReg2), .oMemReq(oMemReq), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemByteEn(oMemByteEn), .iMemAck(iMemAck),
        .iMemRData(iMemRData), .oLoadData(oLoadData), .oLoadValid(oLoadValid), .oStall(oStall),
        .oAddrError(oAddrError), .oBusError(oBusError), .dbgState(dbgState)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes: a store's size comes from cMemWrite, a load's from cSEMux.
    function automatic int accBytes(input logic [1:0] wr, input logic [1:0] se);
        if (wr == 2'd1) return 4;
        if (wr == 2'd2) return 2;
        if (wr == 2'd3) return 1;
        if (se == 2'd0) return 4;
        if (se == 2'd1) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [31:0] addr,
                                              input logic [1:0] se);
        logic [31:0] v;
        v = rd >> (8 * addr[1:0]);
        case (se)
            2'd0: return rd;
            2'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; return v; end
            2'd2: begin v = v % 256; if (v >= 128) v = v + 32'hFFFF_FF00; return v; end
            default: return v % 256;
        endcase
    endfunction

    // One full access from IDLE back to IDLE; ackDelay = BUSY cycle carrying the ack, 0 = never.
    task automatic doAccess(input string tag, input logic rd, input logic [1:0] wr,
                            input logic [1:0] se, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ackDelay);
        int          sz, expReq, stallN, reqN, lvN, aeN, beN;
        bit          al, isLoad, doneSeen, unstable;
        logic [31:0] gotLoad, fAddr, fWData, expWData;
        logic [3:0]  fBe;
        logic        fWe;
        sz       = accBytes(wr, se);
        al       = (addr % sz) == 0;
        isLoad   = (wr == 2'd0);
        stallN = 0; reqN = 0; lvN = 0; aeN = 0; beN = 0;
        doneSeen = 0; unstable = 0; gotLoad = 32'd0;
        fAddr = 32'd0; fWData = 32'd0; fBe = 4'd0; fWe = 1'b0;
        cMemRead = rd; cMemWrite = wr; cSEMux = se; ALUResult = addr; ReadReg2 = wd;
        iMemAck = 1'b0; iMemRData = $urandom;
        #1;
        for (int cyc = 0; cyc < 40 && !doneSeen; cyc++) begin
            if (oStall) stallN++;
            if (oLoadValid) begin lvN++; gotLoad = oLoadData; end
            if (oAddrError) aeN++;
            if (oBusError) beN++;
            if (oMemReq) begin
                reqN++;
                if (reqN == 1) begin
                    fAddr = oMemAddr; fWData = oMemWData; fBe = oMemByteEn; fWe = oMemWe;
                end else if (oMemAddr !== fAddr || oMemWData !== fWData ||
                             oMemByteEn !== fBe || oMemWe !== fWe) begin
                    unstable = 1;
                end
                iMemAck = (reqN == ackDelay);
                iMemRData = iMemAck ? rdata : $urandom;
            end else begin
                iMemAck = 1'b0;
            end
            if (stallN > 0 && !oStall) begin
                doneSeen = 1;
                cMemRead = 1'b0; cMemWrite = 2'd0;
            end
            @(posedge Clk); #1;
        end
        check({tag, ".done"}, 32'(doneSeen), 32'd1);
        check({tag, ".idleStall"}, 32'(oStall), 32'd0);
        check({tag, ".idlePulses"}, {29'd0, oLoadValid, oAddrError, oBusError}, 32'd0);
        if (al) begin
            expReq = (ackDelay == 0) ? TIMEOUT : ackDelay;
            expWData = (sz == 4) ? wd : (sz == 2) ? (wd % 65536) * 32'h0001_0001
                                                  : (wd % 256) * 32'h0101_0101;
            check({tag, ".reqCycles"}, reqN, expReq);
            check({tag, ".stallCycles"}, stallN, expReq + 1);
            check({tag, ".addr"}, fAddr, addr - (addr % 4));
            check({tag, ".we"}, 32'(fWe), 32'(!isLoad));
            check({tag, ".byteEn"}, 32'(fBe), isLoad ? 32'hF : ((1 << sz) - 1) << (addr % 4));
            check({tag, ".wdata"}, fWData, isLoad ? 32'd0 : expWData);
            check({tag, ".stable"}, 32'(unstable), 32'd0);
            check({tag, ".addrErr"}, aeN, 0);
            check({tag, ".busErr"}, beN, (ackDelay == 0) ? 1 : 0);
            check({tag, ".loadValid"}, lvN, (isLoad && ackDelay != 0) ? 1 : 0);
            if (ackDelay == 0) begin
                lastLoad = 32'd0; loadKnown = 1;
            end else if (isLoad) begin
                lastLoad = modelLoad(rdata, addr, se); loadKnown = 1;
                check({tag, ".loadData"}, gotLoad, lastLoad);
            end
        end else begin
            check({tag, ".reqCycles"}, reqN, 0);
            check({tag, ".stallCycles"}, stallN, 1);
            check({tag, ".addrErr"}, aeN, 1);
            check({tag, ".busErr"}, beN, 0);
            check({tag, ".loadValid"}, lvN, 0);
            loadKnown = 0;
        end
        if (loadKnown) check({tag, ".loadHeld"}, oLoadData, lastLoad);
    endtask

    initial begin
        logic        rd;
        logic [1:0]  wr, se;
        logic [31:0] addr;
        int          sz, dly;

        // Reset with a load visible: nothing may stall or be driven.
        Reset = 1'b1; cMemRead = 1'b1; cMemWrite = 2'd0; cSEMux = 2'd0;
        ALUResult = 32'h100; ReadReg2 = 32'd0; iMemAck = 1'b0; iMemRData = 32'd0;
        #12;
        check("rst.req", 32'(oMemReq), 32'd0);
        check("rst.we", 32'(oMemWe), 32'd0);
        check("rst.addr", oMemAddr, 32'd0);
        check("rst.wdata", oMemWData, 32'd0);
        check("rst.byteEn", 32'(oMemByteEn), 32'd0);
        check("rst.loadData", oLoadData, 32'd0);
        check("rst.pulses", {29'd0, oLoadValid, oAddrError, oBusError}, 32'd0);
        check("rst.stall", 32'(oStall), 32'd0);
        cMemRead = 1'b0;
        #1 Reset = 1'b0;
        lastLoad = 32'd0; loadKnown = 1;
        @(posedge Clk); #1;

        doAccess("wordLoad", 1'b1, 2'd0, 2'd0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
        doAccess("byteLoadSx", 1'b1, 2'd0, 2'd2, 32'h103, 32'h0, 32'h80FF_0000, 1);
        doAccess("byteLoadZx", 1'b1, 2'd0, 2'd3, 32'h103, 32'h0, 32'h80FF_0000, 2);
        doAccess("halfLoadHi", 1'b1, 2'd0, 2'd1, 32'h206, 32'h0, 32'h9ABC_1234, 1);
        doAccess("halfStore", 1'b0, 2'd2, 2'd0, 32'h202, 32'h1234_ABCD, 32'h0, 2);
        doAccess("storeWinsRead", 1'b1, 2'd3, 2'd0, 32'h301, 32'h0000_00A5, 32'h0, 1);
        doAccess("misalignWord", 1'b1, 2'd0, 2'd0, 32'h101, 32'h0, 32'h0, 1);
        doAccess("misalignHalfSt", 1'b0, 2'd2, 2'd0, 32'h203, 32'h5555_6666, 32'h0, 1);
        doAccess("wordStoreTimeout", 1'b0, 2'd1, 2'd0, 32'h400, 32'hCAFE_F00D, 32'h0, 0);

        // Ack while idle is ignored.
        iMemAck = 1'b1; iMemRData = 32'h1111_2222;
        @(posedge Clk); #1;
        iMemAck = 1'b0;
        check("idleAck.loadValid", 32'(oLoadValid), 32'd0);
        check("idleAck.req", 32'(oMemReq), 32'd0);

        // Held misaligned op: DONE starts nothing, then the next access follows after it.
        cMemRead = 1'b1; cSEMux = 2'd0; ALUResult = 32'h101;
        #1 check("b2b.stall0", 32'(oStall), 32'd1);
        @(posedge Clk); #1;
        check("b2b.done1Stall", 32'(oStall), 32'd0);
        check("b2b.done1Err", 32'(oAddrError), 32'd1);
        @(posedge Clk); #1;
        check("b2b.stall2", 32'(oStall), 32'd1);
        check("b2b.err2", 32'(oAddrError), 32'd0);
        @(posedge Clk); #1;
        check("b2b.done3Err", 32'(oAddrError), 32'd1);
        check("b2b.req", 32'(oMemReq), 32'd0);
        cMemRead = 1'b0;
        @(posedge Clk); #1;
        check("b2b.idleStall", 32'(oStall), 32'd0);
        loadKnown = 0;

        // Reset in the second BUSY cycle, late ack on the following cycle.
        cMemRead = 1'b1; cSEMux = 2'd0; ALUResult = 32'h500;
        @(posedge Clk); #1;
        check("midRst.busy1Req", 32'(oMemReq), 32'd1);
        @(posedge Clk); #1;
        #2 Reset = 1'b1;
        #1;
        check("midRst.reqDrop", 32'(oMemReq), 32'd0);
        check("midRst.stall", 32'(oStall), 32'd0);
        cMemRead = 1'b0;
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        iMemAck = 1'b1; iMemRData = 32'h7777_8888;
        check("midRst.idleReq", 32'(oMemReq), 32'd0);
        @(posedge Clk); #1;
        iMemAck = 1'b0;
        check("midRst.noLoadValid", 32'(oLoadValid), 32'd0);
        check("midRst.stallAfter", 32'(oStall), 32'd0);
        check("midRst.loadData", oLoadData, 32'd0);
        lastLoad = 32'd0; loadKnown = 1;

        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 2'($urandom_range(0, 3));
            se = 2'($urandom_range(0, 3));
            if (!rd && wr == 2'd0) rd = 1'b1;
            addr = $urandom;
            sz = accBytes(wr, se);
            if ($urandom_range(0, 2) != 0) addr = addr - (addr % sz);
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            doAccess($sformatf("rand%0d", n), rd, wr, se, addr, $urandom, $urandom, dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory controls (cMemRead, cMemWrite, cSEMux), the address (ALUResult) and the store data (ReadReg2).
- Drives a variable-latency data memory over a req/ack handshake and handles byte/half/word lanes and load extension.
- Holds the pipeline with oStall until each access completes.

Parameters:
TIMEOUT, 16, number of BUSY cycles without iMemAck before the access is aborted with oBusError.

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
cMemRead  input  1  load request from EX/MEM
cMemWrite  input  2  00 none, 01 word store, 10 half store, 11 byte store
cSEMux  input  2  load form: 00 word, 01 half sign-ext, 10 byte sign-ext, 11 byte zero-ext
ALUResult  input  32  byte address
ReadReg2  input  32  store data (low bits used for half/byte)
oMemReq  output  1  memory request, held until ack
oMemWe  output  1  1 = write, 0 = read
oMemAddr  output  32  word address, {ALUResult[31:2],2'b00}
oMemWData  output  32  lane-replicated store data
oMemByteEn  output  4  byte lane enables
iMemAck  input  1  one-cycle completion strobe
iMemRData  input  32  read word, valid with iMemAck
oLoadData  output  32  extracted/extended load result
oLoadValid  output  1  one-cycle pulse, oLoadData valid
oStall  output  1  freeze upstream stages and EX/MEM
oAddrError  output  1  one-cycle pulse, misaligned access
oBusError  output  1  one-cycle pulse, ack timeout

Behaviour:
- Reset is asynchronous and active-high. On Reset, state = IDLE, the timeout counter = 0, and every registered output is 0: oMemReq, oMemWe, oMemAddr, oMemWData, oMemByteEn, oLoadData, oLoadValid, oAddrError, oBusError. oStall is 0 while in reset.
- Op present: op = cMemRead | (cMemWrite != 0).
- Simultaneous cMemRead and nonzero cMemWrite: the store is performed and the read is ignored.
- Alignment:
  - Word access requires ALUResult[1:0] == 0.
  - Half access requires ALUResult[0] == 0.
  - Byte access is always aligned.
  - For loads, the size is taken from cSEMux.
- Lanes are little-endian: byte offset 0 is bits [7:0].
- Store byte enables and data:
  - Byte store: oMemByteEn = 1 << addr[1:0], oMemWData = {4{ReadReg2[7:0]}}.
  - Half store: oMemByteEn = 0011 or 1100, oMemWData = {2{ReadReg2[15:0]}}.
  - Word store: oMemByteEn = 1111, oMemWData = ReadReg2.
  - Loads: oMemByteEn = 1111, oMemWData = 0.
- State machine:
  - IDLE:
    - On op with an aligned address: latch oMemAddr, oMemWe, oMemWData, oMemByteEn, the load form and addr[1:0]. Set oMemReq = 1, go to BUSY.
    - On op with a misaligned address: issue no request, set oAddrError = 1, go to DONE.
    - No op: stay in IDLE.
  - BUSY:
    - oMemReq stays 1 and all request fields stay stable. The counter increments each cycle.
    - On iMemAck: oMemReq = 0. For a read, oLoadData = the extracted lane extended per the latched form, and oLoadValid = 1. Go to DONE.
    - If the counter reaches TIMEOUT-1 without ack: oMemReq = 0, oBusError = 1, oLoadData = 0. Go to DONE.
  - DONE:
    - Lasts exactly 1 cycle; the EX/MEM register advances during it.
    - No new access is started even if op is still visible.
    - Clear oLoadValid, oAddrError, oBusError and the counter. Go to IDLE.
- oStall (combinational) = (IDLE & op) | BUSY. It is 0 in DONE.
- Minimum cycles held: aligned access with ack on the first BUSY cycle = 2 stall cycles (IDLE cycle plus 1 BUSY); misaligned access = 1 stall cycle.
- oLoadData keeps its value until the next load or error overwrites it.
- iMemAck seen in IDLE or DONE is ignored.
- Reset mid-BUSY drops oMemReq immediately, asynchronously. A late ack arriving after reset is ignored.
- Back-to-back memory ops cost 1 DONE cycle between them.

Test Plan:
- Word load at 0x100, ack after 3 BUSY cycles with iMemRData = 0xDEADBEEF -> oMemAddr = 0x100, oMemByteEn = 1111, oStall high 4 cycles, oLoadValid pulse with oLoadData = 0xDEADBEEF.
- Byte loads at 0x103 with iMemRData = 0x80FF_0000, cSEMux = 10 then 11 -> 0xFFFFFF80, then 0x00000080.
- Half store at 0x202 with ReadReg2 = 0x1234ABCD -> oMemAddr = 0x200, oMemByteEn = 1100, oMemWData = 0xABCDABCD, oMemWe = 1, oLoadValid stays 0.
- Word load at 0x101 -> no oMemReq ever; oAddrError pulse; oStall high exactly 1 cycle.
- Word store, no ack with TIMEOUT = 16 -> oMemReq held 16 cycles then drops; oBusError pulse; DONE, then IDLE.
- Reset asserted in the 2nd BUSY cycle, with ack in the following cycle -> oMemReq = 0 immediately, state IDLE, the ack is ignored, no oLoadValid.
